// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - CPU-side register bus for the buffered UART transmitter
interface uart_tx_fifo_if #(
  parameter int RDATA_W = 64
);
  logic               cen;
  logic               wr;
  logic               addr;
  logic [7:0]         wdata;
  logic [RDATA_W-1:0] rdata;
  logic               error;

  modport master (output cen, wr, addr, wdata, input rdata, error);
  modport slave  (input cen, wr, addr, wdata, output rdata, error);
endinterface

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - FIFO-buffered 8N1 UART transmitter with a pollable status register
module uart_tx_fifo #(
  parameter int DEPTH        = 16,
  parameter int CLKS_PER_BIT = 4,
  parameter int RDATA_W      = 64
) (
  input  logic          clk,
  input  logic          rstn,
  uart_tx_fifo_if.slave bus,
  output logic          txd,
  output logic          busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [7:0]         mem [DEPTH];
  logic [AW:0]        wr_ptr;
  logic [AW:0]        rd_ptr;
  logic [AW:0]        count;
  logic               empty;
  logic               full;
  logic               push;
  logic               pop;
  logic               bit_end;
  logic [7:0]         shreg;
  logic [BW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [RDATA_W-1:0] status;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = bus.cen && bus.wr && !bus.addr && !full;
  assign pop     = (state == IDLE) && !empty;
  assign bit_end = (baud_cnt == BAUD_LAST);
  assign busy    = (state != IDLE) || !empty;

  // Full is judged on the pre-edge pointers, so a write while full is refused even if a pop lands this cycle.
  assign bus.error = bus.cen && ((bus.wr && (bus.addr || full)) || (!bus.wr && !bus.addr));

  always_comb begin
    status = '0;
    if (bus.cen && !bus.wr && bus.addr) begin
      status[0]    = empty;
      status[1]    = full;
      status[2]    = (state != IDLE);
      status[15:8] = 8'(count);
    end
  end
  assign bus.rdata = status;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // txd is registered and set on each transition, so the line level always matches the state being entered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= IDLE;
      txd      <= 1'b1;
      shreg    <= '0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (!empty) begin
            shreg    <= mem[rd_ptr[AW-1:0]];
            baud_cnt <= '0;
            txd      <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            txd      <= shreg[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              txd   <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          txd <= 1'b1;
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int CPB   = 4;
  localparam int RW    = 64;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic txd;
  logic busy;

  uart_tx_fifo_if #(.RDATA_W(RW)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB), .RDATA_W(RW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .txd  (txd),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int errors   = 0;
  int stop_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];
  int         st_q[$];
  logic [7:0] m_b;
  logic       m_ab;
  int         m_st;

  // Line receiver: samples mid-bit on falling clock edges, drops frames cut by reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && txd === 1'b0) begin
        m_st = cyc;
        m_ab = 1'b0;
        repeat (CPB / 2) @(negedge clk);
        m_ab = m_ab | !rstn;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          m_b[i] = txd;
          m_ab   = m_ab | !rstn;
        end
        repeat (CPB) @(negedge clk);
        m_ab = m_ab | !rstn;
        if (!m_ab) begin
          if (txd !== 1'b1) stop_bad++;
          rx_q.push_back(m_b);
          st_q.push_back(m_st);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic access(input logic w, input logic a, input logic [7:0] d,
                        output logic e, output logic [63:0] rd);
    @(negedge clk);
    bus.cen = 1'b1; bus.wr = w; bus.addr = a; bus.wdata = d;
    #1;
    e  = bus.error;
    rd = bus.rdata;
    @(posedge clk);
    #1;
    bus.cen = 1'b0; bus.wr = 1'b0; bus.addr = 1'b0;
  endtask

  task automatic put(input logic [7:0] d, input logic exp_err, input string tag);
    logic e;
    logic [63:0] rd;
    access(1'b1, 1'b0, d, e, rd);
    chk(tag, e, exp_err);
    if (!exp_err) exp_q.push_back(d);
  endtask

  function automatic logic [63:0] st(input logic emp, input logic ful, input logic txb, input int cnt);
    return {48'b0, 8'(cnt), 5'b0, txb, ful, emp};
  endfunction

  task automatic status_chk(input string tag, input logic [63:0] want);
    logic e;
    logic [63:0] rd;
    access(1'b0, 1'b1, 8'h00, e, rd);
    chk(tag, rd, want);
    chk({tag, "_err"}, e, 1'b0);
  endtask

  task automatic check_rx(input int n, input string tag);
    for (int i = 0; i < 4000 && rx_q.size() < n; i++) @(negedge clk);
    chk({tag, "_count"}, rx_q.size(), n);
    while (rx_q.size() > 0 && exp_q.size() > 0) begin
      chk(tag, rx_q.pop_front(), exp_q.pop_front());
      void'(st_q.pop_front());
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 2000 && busy; i++) @(negedge clk);
    chk(tag, busy, 1'b0);
  endtask

  initial begin
    logic        e;
    logic [63:0] rd;
    logic        exp_txd;
    int          t0;
    int          bi;

    bus.cen = 1'b0; bus.wr = 1'b0; bus.addr = 1'b0; bus.wdata = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_txd", txd, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_rdata_idle", bus.rdata, 64'h0);
    chk("rst_error_idle", bus.error, 1'b0);
    rstn = 1'b1;
    status_chk("rst_status", st(1'b1, 1'b0, 1'b0, 0));

    // Single frame 0x55, cycle-accurate line and busy
    put(8'h55, 1'b0, "t1_err");
    t0 = cyc;
    for (int k = 0; k < 45; k++) begin
      @(negedge clk);
      if (k == 0 || k >= 37) exp_txd = 1'b1;
      else if (k <= 4) exp_txd = 1'b0;
      else begin
        bi = (k - 5) / CPB;
        exp_txd = (8'h55 >> bi) & 1'b1;
      end
      chk($sformatf("t1_txd_%0d", cyc - t0), txd, exp_txd);
      chk($sformatf("t1_busy_%0d", cyc - t0), busy, (k < 41));
    end
    check_rx(1, "t1_data");

    // Back-to-back frames
    put(8'hA3, 1'b0, "t2_err0");
    put(8'h01, 1'b0, "t2_err1");
    for (int i = 0; i < 4000 && rx_q.size() < 2; i++) @(negedge clk);
    chk("t2_gap", (rx_q.size() >= 2) ? (st_q[1] - st_q[0]) : -1, 41);
    check_rx(2, "t2_data");
    wait_idle("t2_idle");

    // Fill, overflow, drop
    for (int i = 0; i < 16; i++) put(8'h10 + 8'(i), 1'b0, $sformatf("t3_err_%0d", i));
    status_chk("t3_status15", st(1'b0, 1'b0, 1'b1, 15));
    put(8'h20, 1'b0, "t3_refill_err");
    status_chk("t3_status_full", st(1'b0, 1'b1, 1'b1, 16));
    put(8'h99, 1'b1, "t3_overflow_err");
    check_rx(17, "t3_data");
    repeat (120) @(negedge clk);
    chk("t3_no_extra", rx_q.size(), 0);
    wait_idle("t3_idle");

    // Illegal accesses
    access(1'b1, 1'b1, 8'hAB, e, rd);
    chk("t4_wr_status_err", e, 1'b1);
    access(1'b0, 1'b0, 8'h00, e, rd);
    chk("t4_rd_txdata_err", e, 1'b1);
    chk("t4_rd_txdata_rdata", rd, 64'h0);
    status_chk("t4_status", st(1'b1, 1'b0, 1'b0, 0));
    repeat (60) @(negedge clk);
    chk("t4_no_frame", rx_q.size(), 0);
    chk("t4_busy", busy, 1'b0);

    // Reset in the middle of a data bit
    for (int i = 0; i < 3; i++) begin
      access(1'b1, 1'b0, 8'h00, e, rd);
      chk($sformatf("t5_err_%0d", i), e, 1'b0);
    end
    repeat (8) @(negedge clk);
    chk("t5_pre_txd", txd, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_async_txd", txd, 1'b1);
    chk("t5_async_busy", busy, 1'b0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    status_chk("t5_status", st(1'b1, 1'b0, 1'b0, 0));
    chk("t5_busy", busy, 1'b0);
    repeat (100) @(negedge clk);
    chk("t5_no_frame", rx_q.size(), 0);
    chk("t5_busy_late", busy, 1'b0);

    // Push and pop on the same edge
    put(8'h5A, 1'b0, "t6_err0");
    put(8'h7E, 1'b0, "t6_err1");
    status_chk("t6_status", st(1'b0, 1'b0, 1'b1, 1));
    check_rx(2, "t6_data");
    wait_idle("t6_idle");

    chk("stop_bits", stop_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
